rot_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single parametric left-rotate datapath between `R` requesters. Each requester presents a word and a rotate amount over a valid/ready handshake. The block grants one requester per cycle, rotates the word left by the amount, and registers the result into a one-entry output stage with its own valid/ready handshake and a requester ID. It sits between multiple client blocks and the single shared rotator.

---
 rtl/rot_pkg.sv | 20 ++
 rtl/rotl_core.sv | 18 +
 rtl/rot_arbiter.sv | 85 ++++++++
 tb/tb_rot_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared types and helpers for the round-robin rotate arbiter.
// Imported by the arbiter, the rotator and the bench.
package rot_pkg;

    localparam int N = 3;
    localparam int R = 4;

    typedef logic [2**N-1:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rot_state_t;

    // Pointer moves one past the winner only when a request is taken.
    function automatic int rr_next(int ptr, int g, logic take, int nreq);
        return take ? (g + 1) % nreq : ptr;
    endfunction

endpackage

// File: rtl/rotl_core.sv
// Combinational left rotator: y = a rotated left by amt, mod 2**N.
// Reusable outside the arbiter.
module rotl_core #(
    parameter int N = 3,
    localparam int W = 2**N
) (
    input  logic [W-1:0] a,
    input  logic [N-1:0] amt,
    output logic [W-1:0] y
);

    logic [2*W-1:0] dbl;

    // Upper half of the shifted double word holds the wrapped bits.
    assign dbl = {a, a} << amt;
    assign y   = dbl[2*W-1:W];

endmodule

// File: rtl/rot_arbiter.sv
// Round-robin arbiter sharing one left rotator among R requesters,
// with a one-entry registered output stage.
module rot_arbiter
    import rot_pkg::*;
#(
    parameter int N = 3,
    parameter int R = 4,
    localparam int W  = 2**N,
    localparam int IW = $clog2(R)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [R-1:0]          req_valid,
    output logic [R-1:0]          req_ready,
    input  logic [R-1:0][W-1:0]   req_data,
    input  logic [R-1:0][N-1:0]   req_amt,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [W-1:0]          rsp_data,
    output logic [IW-1:0]         rsp_id
);

    rot_state_t    state_q;
    rot_state_t    state_d;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] g;
    logic          found;
    int            idx;
    logic          any;
    logic          slot_free;
    logic          accept;
    logic [W-1:0]  rot_y;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        g     = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < R; k++) begin
            idx = (int'(ptr_q) + k) % R;
            if (!found && req_valid[idx]) begin
                g     = IW'(idx);
                found = 1'b1;
            end
        end
    end

    assign any       = |req_valid;
    assign slot_free = (state_q == IDLE) | rsp_ready;
    assign accept    = slot_free & any;
    assign req_ready = accept ? (R'(1) << g) : '0;
    assign rsp_valid = (state_q == HOLD);

    rotl_core #(.N(N)) u_rot (
        .a   (req_data[g]),
        .amt (req_amt[g]),
        .y   (rot_y)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = HOLD;
            HOLD: if (rsp_ready && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= IW'(rr_next(int'(ptr_q), int'(g), accept, R));
            if (accept) begin
                rsp_data <= rot_y;
                rsp_id   <= g;
            end
        end
    end

endmodule

// File: tb/tb_rot_arbiter.sv
// Scoreboard bench for rot_arbiter (N=3, R=4) with an
// independent arbiter/rotator reference model.
module tb_rot_arbiter;
    import rot_pkg::*;

    typedef struct {
        logic [1:0] id;
        word_t      data;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [R-1:0]       req_valid = '0;
    logic [R-1:0]       req_ready;
    logic [R-1:0][7:0]  req_data = '0;
    logic [R-1:0][N-1:0] req_amt = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic [7:0]         rsp_data;
    logic [1:0]         rsp_id;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    logic full_m = 1'b0;
    int   ptr_m = 0;

    rot_arbiter #(.N(3), .R(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic word_t rotl_ref(word_t a, int amt);
        word_t y;
        y = '0;
        for (int i = 0; i < 8; i++) y[(i + amt) % 8] = a[i];
        return y;
    endfunction

    // Check at negedge, advance model, return at posedge + 1.
    task automatic step();
        int           g_m;
        logic         found;
        logic         slot;
        logic [R-1:0] exp_rdy;
        @(negedge clk);
        chk("rsp_valid", rsp_valid, full_m);
        if (full_m && sb.size() > 0) begin
            chk("rsp_data", rsp_data, sb[0].data);
            chk("rsp_id", rsp_id, sb[0].id);
        end
        g_m = 0;
        found = 1'b0;
        for (int k = 0; k < R; k++) begin
            if (!found && req_valid[(ptr_m + k) % R]) begin
                g_m = (ptr_m + k) % R;
                found = 1'b1;
            end
        end
        slot = !full_m || rsp_ready;
        exp_rdy = (slot && found) ? (R'(1) << g_m) : '0;
        chk("req_ready", req_ready, exp_rdy);
        if (full_m && rsp_ready) begin
            void'(sb.pop_front());
            full_m = 1'b0;
        end
        if (slot && found) begin
            sb.push_back('{2'(g_m), rotl_ref(req_data[g_m], int'(req_amt[g_m]))});
            full_m = 1'b1;
            ptr_m = (g_m + 1) % R;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sb.delete();
        full_m = 1'b0;
        ptr_m = 0;
    endtask

    task automatic single(int i, word_t d, int a, word_t exp);
        req_valid = '0;
        req_valid[i] = 1'b1;
        req_data[i] = d;
        req_amt[i] = N'(a);
        step();
        chk("one_data", rsp_data, exp);
        chk("one_id", rsp_id, i);
        chk("one_valid", rsp_valid, 1);
    endtask

    int fair_seq[5] = '{0, 1, 2, 3, 0};

    initial begin
        @(posedge clk);
        #1;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_id", rsp_id, 0);
        reset_n = 1'b1;
        model_reset();

        single(0, 8'b1000_0001, 1, 8'b0000_0011);
        single(1, 8'hA5, 0, 8'hA5);
        single(2, 8'h01, 7, 8'h80);
        single(3, 8'h3C, 4, 8'hC3);
        req_valid = '0;
        step();

        for (int i = 0; i < R; i++) begin
            req_data[i] = 8'(8'h11 * (i + 1));
            req_amt[i] = N'(i + 1);
        end
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("fair_id", rsp_id, fair_seq[i]);
            chk("fair_valid", rsp_valid, 1);
        end

        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_id", rsp_id, 0);
            chk("bp_data", rsp_data, 8'h22);
            chk("bp_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        step();
        chk("refill_id", rsp_id, 1);
        chk("refill_valid", rsp_valid, 1);

        rsp_ready = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", rsp_valid, 0);
        chk("arst_data", rsp_data, 0);
        chk("arst_id", rsp_id, 0);
        req_valid = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("post_rst_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        step();

        req_valid = 4'b0101;
        step();
        chk("skip_first", rsp_id, 2);
        req_valid = 4'b0001;
        step();
        chk("skip_second", rsp_id, 0);
        req_valid = 4'b1111;
        #1;
        chk("skip_ptr", req_ready, 4'b0010);
        req_valid = '0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
